// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared types and helpers for bit_serial_adder.
//   - state_e   : FSM state encoding (IDLE -> RUN -> DONE -> IDLE), 2 bits.
//   - cnt_width : bit-count counter width as a function of the operand WIDTH.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width for a WIDTH-step serial pass: values 0..WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Single-bit full adder.
//   Ports:
//     a, b  in  1  operand bits
//     cin   in  1  carry in
//     sum   out 1  a ^ b ^ cin
//     cout  out 1  carry out
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/bit_serial_adder.sv
// -----------------------------------------------------------------------------
// bit_serial_adder
//   WIDTH-bit adder built around one full_adder, processing one bit per cycle,
//   LSB first. Operands are taken with a valid/ready handshake, the result is
//   offered with a valid/ready handshake.
//
//   Parameters:
//     WIDTH      operand/sum width (>= 2)
//   Ports:
//     clk        in   1      rising-edge clock
//     rst_n      in   1      synchronous, active-low reset
//     in_valid   in   1      a/b/cin valid
//     in_ready   out  1      high only in IDLE
//     a, b       in   WIDTH  operands
//     cin        in   1      carry into bit 0
//     out_valid  out  1      high only in DONE
//     out_ready  in   1      consumer accepts result
//     sum        out  WIDTH  a + b + cin mod 2^WIDTH
//     cout       out  1      carry out of bit WIDTH-1
//     busy       out  1      high in RUN or DONE
//     ovf        out  1      signed overflow (only with SERIAL_ADDER_OVF_EN)
//
//   Configuration macro: SERIAL_ADDER_OVF_EN adds the ovf port and its flop.
// -----------------------------------------------------------------------------
module bit_serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q,  state_d;
  logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic               carry_q,  carry_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q,    ovf_d;
`endif

  logic fa_s;
  logic fa_c;

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_c)
  );

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end

      RUN: begin
        // Sum bits enter at the MSB; after WIDTH shifts bit 0 sits at the LSB.
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d  = fa_c;
        if (cnt_q == CNT_LAST) begin
          // Counter is left at its last value so it never wraps.
          state_d = DONE;
`ifdef SERIAL_ADDER_OVF_EN
          // Carry into the MSB xor carry out of the MSB.
          ovf_d   = carry_q ^ fa_c;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous (sampled only at the clock edge), and all state
  // uses non-blocking assignment so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Handshake outputs decode from the state register only.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_sr_q;
  assign cout      = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule : bit_serial_adder

// File: tb/tb_bit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_adder
//   Directed and random stimulus for bit_serial_adder (WIDTH=8). Expected
//   results are queued at operand acceptance and compared on output handshake.
//   Define SERIAL_ADDER_OVF_EN for both files to also check ovf.
// -----------------------------------------------------------------------------
module tb_bit_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  bit_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   last_accept = 0;
  int   accept_gap  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition; signed overflow from carries at the MSB.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c);
    exp_t             e;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] low;
    full   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    low    = {1'b0, x[WIDTH-2:0]} + {1'b0, y[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, c};
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.ovf  = low[WIDTH-1] ^ full[WIDTH];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait for in_ready (bounded), take the accept edge.
  // With hold_valid, in_valid stays high with junk operands afterwards.
  task automatic send(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                      input logic xc, input bit hold_valid);
    int n;
    in_valid = 1'b1;
    a = xa;
    b = xb;
    cin = xc;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", in_ready, 1);
    tick();
    accept_gap  = cyc - last_accept;
    last_accept = cyc;
    sb.push_back(model(xa, xb, xc));
    check("in_ready_low_after_accept", in_ready, 0);
    check("busy_after_accept", busy, 1);
    if (hold_valid) begin
      a   = WIDTH'($urandom);
      b   = WIDTH'($urandom);
      cin = 1'($urandom);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  // Wait (bounded) for the output handshake, compare against the scoreboard.
  task automatic recv(input bit rand_ready, output int lat);
    exp_t e;
    int   n;
    n = 0;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!(out_valid && out_ready) && n < 200) begin
      tick();
      n++;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    lat = n;
    check("out_valid_seen", out_valid, 1);
    check("scoreboard_nonempty", (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sum", sum, e.sum);
      check("cout", cout, e.cout);
`ifdef SERIAL_ADDER_OVF_EN
      check("ovf", ovf, e.ovf);
`endif
    end
    tick();
    out_ready = 1'b0;
    check("out_valid_low_after_handshake", out_valid, 0);
  endtask

  initial begin
    int               lat;
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;
    bit               saw_valid;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 1);

    // T1: basic add, latency WIDTH edges after acceptance.
    send(8'h5A, 8'h3C, 1'b0, 1'b0);
    recv(1'b0, lat);
    check("t1_latency", lat, WIDTH);
    check("t1_sum_kept_after_handshake", sum, 8'h96);

    // T2: full carry propagation.
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    recv(1'b0, lat);
    send(8'hFF, 8'h00, 1'b1, 1'b0);
    recv(1'b0, lat);

    // T3: stall in DONE; an in_valid pulse must not be taken.
    send(8'hA5, 8'h5A, 1'b1, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("t3_done_reached", out_valid, 1);
    held_sum  = sum;
    held_cout = cout;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      a = 8'h11;
      b = 8'h22;
      tick();
      check("t3_sum_stable", sum, held_sum);
      check("t3_cout_stable", cout, held_cout);
      check("t3_in_ready_low", in_ready, 0);
      check("t3_out_valid_held", out_valid, 1);
    end
    in_valid = 1'b0;
    recv(1'b0, lat);
    tick();
    tick();
    check("t3_no_pulsed_op_busy", busy, 0);
    check("t3_no_pulsed_op_ready", in_ready, 1);

    // T4: reset during RUN at cnt=3 aborts without a result.
    send(8'h0F, 8'h0F, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("t4_rst_out_valid", out_valid, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_in_ready", in_ready, 1);
    check("t4_rst_sum", sum, 0);
    rst_n = 1'b1;
    void'(sb.pop_back());
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      saw_valid = saw_valid | out_valid;
    end
    check("t4_no_out_valid_after_abort", saw_valid, 0);
    send(8'h01, 8'h02, 1'b0, 1'b0);
    recv(1'b0, lat);

`ifdef SERIAL_ADDER_OVF_EN
    // T5: signed overflow.
    send(8'h7F, 8'h01, 1'b0, 1'b0);
    recv(1'b0, lat);
    send(8'h80, 8'h80, 1'b0, 1'b0);
    recv(1'b0, lat);
    send(8'h10, 8'h20, 1'b0, 1'b0);
    recv(1'b0, lat);
`endif

    // T6: random back-to-back ops, in_valid held high, random out_ready.
    for (int i = 0; i < 100; i++) begin
      send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
      if (i > 0) check("t6_min_interval", (accept_gap >= WIDTH + 2), 1);
      recv(1'b1, lat);
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("t6_scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bit_serial_adder
